// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte buffer behind UART_RX
// Stores error-free frames only; keeps sticky overflow and saturating error counts.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATA_WIDTH-1:0]      P_DATA,
  input  logic                       Data_Valid,
  input  logic                       Parity_Error,
  input  logic                       Stop_Error,
  input  logic                       RD_EN,
  input  logic                       CLR_ERR,
  output logic [DATA_WIDTH-1:0]      RD_DATA,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic [$clog2(DEPTH):0]     FILL_LEVEL,
  output logic                       OVERFLOW,
  output logic [CNT_WIDTH-1:0]       PAR_ERR_CNT,
  output logic [CNT_WIDTH-1:0]       STOP_ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         fill;
  logic                  dv_q;
  logic                  pe_q;
  logic                  se_q;

  logic dv_rise;
  logic pe_rise;
  logic se_rise;
  logic accept;
  logic do_pop;
  logic do_write;
  logic ovf_event;

  // Strobes from UART_RX may stay high for several cycles; act only on the rising edge.
  assign dv_rise   = Data_Valid   & ~dv_q;
  assign pe_rise   = Parity_Error & ~pe_q;
  assign se_rise   = Stop_Error   & ~se_q;
  assign accept    = dv_rise & ~Parity_Error & ~Stop_Error;

  assign EMPTY      = (fill == '0);
  assign FULL       = (fill == LW'(DEPTH));
  assign FILL_LEVEL = fill;
  assign do_pop     = RD_EN & ~EMPTY;
  // A same-cycle pop frees the slot, so a full FIFO can still take the byte.
  assign do_write   = accept & (~FULL | do_pop);
  assign ovf_event  = accept & FULL & ~do_pop;

  assign RD_DATA = EMPTY ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
    end else begin
      dv_q <= Data_Valid;
      pe_q <= Parity_Error;
      se_q <= Stop_Error;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem[wr_ptr] <= P_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_write, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Clear takes priority over any same-cycle increment or overflow event.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVERFLOW     <= 1'b0;
      PAR_ERR_CNT  <= '0;
      STOP_ERR_CNT <= '0;
    end else if (CLR_ERR) begin
      OVERFLOW     <= 1'b0;
      PAR_ERR_CNT  <= '0;
      STOP_ERR_CNT <= '0;
    end else begin
      if (ovf_event) begin
        OVERFLOW <= 1'b1;
      end
      if (pe_rise && (PAR_ERR_CNT != '1)) begin
        PAR_ERR_CNT <= PAR_ERR_CNT + 1'b1;
      end
      if (se_rise && (STOP_ERR_CNT != '1)) begin
        STOP_ERR_CNT <= STOP_ERR_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
// Queue-based reference model; monitor compares DUT outputs every falling edge.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 2;
  localparam int MAXC  = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          Parity_Error = 1'b0;
  logic          Stop_Error = 1'b0;
  logic          RD_EN = 1'b0;
  logic          CLR_ERR = 1'b0;
  logic [DW-1:0] RD_DATA;
  logic          EMPTY;
  logic          FULL;
  logic [3:0]    FILL_LEVEL;
  logic          OVERFLOW;
  logic [CW-1:0] PAR_ERR_CNT;
  logic [CW-1:0] STOP_ERR_CNT;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .Parity_Error(Parity_Error), .Stop_Error(Stop_Error), .RD_EN(RD_EN),
    .CLR_ERR(CLR_ERR), .RD_DATA(RD_DATA), .EMPTY(EMPTY), .FULL(FULL),
    .FILL_LEVEL(FILL_LEVEL), .OVERFLOW(OVERFLOW), .PAR_ERR_CNT(PAR_ERR_CNT),
    .STOP_ERR_CNT(STOP_ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: contents as a queue, statistics as plain integers.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] drained[$];
  int  m_par = 0;
  int  m_stop = 0;
  bit  m_ovf = 0;
  bit  pdv = 0, ppe = 0, pse = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mq.delete();
      m_par = 0; m_stop = 0; m_ovf = 0;
      pdv = 0; ppe = 0; pse = 0;
    end else begin
      bit acc, lost;
      acc  = Data_Valid && !pdv && !Parity_Error && !Stop_Error;
      lost = 0;
      if (RD_EN && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        if (mq.size() < DEPTH) mq.push_back(P_DATA);
        else lost = 1;
      end
      if (CLR_ERR) begin
        m_par = 0; m_stop = 0; m_ovf = 0;
      end else begin
        if (lost) m_ovf = 1;
        if (Parity_Error && !ppe && m_par < MAXC) m_par++;
        if (Stop_Error && !pse && m_stop < MAXC) m_stop++;
      end
      pdv = Data_Valid; ppe = Parity_Error; pse = Stop_Error;
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      chk("mon_rd_data", RD_DATA, (mq.size() > 0) ? mq[0] : 0);
      chk("mon_fill", FILL_LEVEL, mq.size());
      chk("mon_empty", EMPTY, mq.size() == 0);
      chk("mon_full", FULL, mq.size() == DEPTH);
      chk("mon_ovf", OVERFLOW, m_ovf);
      chk("mon_par", PAR_ERR_CNT, m_par);
      chk("mon_stop", STOP_ERR_CNT, m_stop);
      if (RD_EN && !EMPTY) drained.push_back(RD_DATA);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input bit pe, input bit se);
    P_DATA = d; Data_Valid = 1; Parity_Error = pe; Stop_Error = se;
    tick();
    Data_Valid = 0; Parity_Error = 0; Stop_Error = 0;
    tick();
  endtask

  task automatic pop_n(input int n);
    RD_EN = 1;
    tick(n);
    RD_EN = 0;
  endtask

  initial begin
    logic [DW-1:0] last;
    #2;
    chk("reset_empty", EMPTY, 1);
    chk("reset_rd_data", RD_DATA, 0);
    chk("reset_fill", FILL_LEVEL, 0);
    chk("reset_ovf", OVERFLOW, 0);
    tick(2);
    RST = 1;
    tick();

    // Asynchronous reset mid-fill
    push(8'h11, 0, 0); push(8'h22, 0, 0); push(8'h33, 0, 0);
    chk("prefill_level", FILL_LEVEL, 3);
    #3 RST = 0;
    #1;
    chk("async_rst_fill", FILL_LEVEL, 0);
    chk("async_rst_empty", EMPTY, 1);
    chk("async_rst_rd_data", RD_DATA, 0);
    tick(2);
    RST = 1;
    tick();
    chk("post_rst_empty", EMPTY, 1);
    chk("post_rst_rd_data", RD_DATA, 0);

    // Basic ordering
    push(8'hA5, 0, 0); push(8'h3C, 0, 0);
    chk("basic_fill", FILL_LEVEL, 2);
    chk("basic_head", RD_DATA, 8'hA5);
    pop_n(1);
    chk("basic_pop1", RD_DATA, 8'h3C);
    pop_n(1);
    chk("basic_pop2_empty", EMPTY, 1);
    chk("basic_pop2_data", RD_DATA, 0);

    // Error rejects
    push(8'hA5, 1, 0);
    chk("par_reject_cnt", PAR_ERR_CNT, 1);
    chk("par_reject_empty", EMPTY, 1);
    push(8'hF3, 0, 1);
    chk("stop_reject_cnt", STOP_ERR_CNT, 1);
    chk("stop_reject_empty", EMPTY, 1);

    // Fill and overflow
    for (int i = 0; i <= 8; i++) push(8'(i), 0, 0);
    chk("fill_full", FULL, 1);
    chk("fill_ovf", OVERFLOW, 1);
    drained.delete();
    pop_n(8);
    chk("drain_count", drained.size(), 8);
    for (int i = 0; i < 8 && i < drained.size(); i++) chk("drain_order", drained[i], i);
    chk("drain_empty", EMPTY, 1);
    CLR_ERR = 1; tick(); CLR_ERR = 0; tick();
    chk("clr_ovf", OVERFLOW, 0);

    // Accept and pop together while full
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i), 0, 0);
    chk("sim_pre_full", FULL, 1);
    P_DATA = 8'h55; Data_Valid = 1; RD_EN = 1;
    tick();
    Data_Valid = 0; RD_EN = 0;
    chk("sim_fill", FILL_LEVEL, 8);
    chk("sim_ovf", OVERFLOW, 0);
    chk("sim_head", RD_DATA, 8'h11);
    tick();
    drained.delete();
    pop_n(8);
    last = (drained.size() > 0) ? drained[drained.size()-1] : 8'h00;
    chk("sim_last", last, 8'h55);

    // Saturation, held strobe, clear priority
    CLR_ERR = 1; tick(); CLR_ERR = 0;
    repeat (5) begin
      Parity_Error = 1; tick(); Parity_Error = 0; tick();
    end
    chk("par_saturate", PAR_ERR_CNT, 3);
    P_DATA = 8'h55; Data_Valid = 1; tick(4); Data_Valid = 0; tick();
    chk("held_dv_fill", FILL_LEVEL, 1);
    chk("held_dv_data", RD_DATA, 8'h55);
    Stop_Error = 1; CLR_ERR = 1; tick(); Stop_Error = 0; CLR_ERR = 0; tick();
    chk("clr_beats_inc", STOP_ERR_CNT, 0);
    chk("clr_keeps_fifo", FILL_LEVEL, 1);

    // Randomised traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if (Data_Valid) Data_Valid = ($urandom_range(0, 3) == 0);
      else Data_Valid = ($urandom_range(0, 1) == 0);
      P_DATA       = 8'($urandom);
      Parity_Error = ($urandom_range(0, 9) == 0);
      Stop_Error   = ($urandom_range(0, 9) == 0);
      RD_EN        = ($urandom_range(0, 9) < ((c / 250) % 2 ? 7 : 3));
      CLR_ERR      = ($urandom_range(0, 49) == 0);
      tick();
    end
    Data_Valid = 0; Parity_Error = 0; Stop_Error = 0; RD_EN = 0; CLR_ERR = 0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
